systolic_ws_array: RTL and testbench
====================================

# systolic_ws_array

Weight-stationary, non-square systolic matrix-multiply engine for the BERT accelerator datapath. It is the parametrised successor of the square PE grid, with four additions: independent `ROWS`/`COLS`, a framed weight-load FSM, internal input skew and output de-skew, and valid/last tracking. Each accepted activation vector `a[0..ROWS-1]` produces one result vector `out[c] = bias[c] + Σr a[r]·W[r][c]`, with all columns aligned in a single cycle. It sits between the activation/bias buffers and the post-processing (requant/softmax) stage.

## Interface
- `DATAWIDTH`, 8: activation and weight width, signed two's complement.
- `ACCWIDTH`, 32: bias, partial-sum and output width, signed.
- `ROWS`, 16: array rows; reduction depth, i.e. activation vector length.
- `COLS`, 16: array columns; output vector length.
- `LAT`, derived as `ROWS+COLS`: fixed accept-to-result latency in cycles; a localparam, not overridable.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wt_valid` in 1: weight row offered.
- `wt_row` in `COLS×DATAWIDTH`: weight row `W[r][0..COLS-1]`; row index `r` is implicit from arrival order.
- `wt_ready` out 1: weight row accepted on an edge where `wt_valid && wt_ready`.
- `act_valid` in 1: activation vector offered.
- `act_in` in `ROWS×DATAWIDTH`: activation vector.
- `bias_in` in `COLS×ACCWIDTH`: per-column initial partial sum, sampled together with `act_in`.
- `act_last` in 1: marks the final vector of a tile; qualified by acceptance.
- `act_ready` out 1: vector accepted on an edge where `act_valid && act_ready`.
- `out_valid` out 1: result vector valid; a one-cycle pulse per accepted vector.
- `out_data` out `COLS×ACCWIDTH`: result vector.
- `out_last` out 1: high with the `out_valid` pulse of the `act_last` vector.
- `wt_loaded` out 1: a complete weight set is resident; high in READY and DRAIN.

## Operation
- FSM states: IDLE, LOAD, READY, DRAIN.
  - IDLE: `wt_ready=1`, `act_ready=0`. An accepted weight row is written to row 0; go to LOAD, or directly to READY if `ROWS==1`.
  - LOAD: `wt_ready=1`, `act_ready=0`. A row counter increments per accepted row (gaps allowed). The row with index `ROWS-1` completes the set; go to READY.
  - READY: `act_ready=1`. `wt_ready = (inflight==0) && !act_valid`, so activations take priority over a weight reload. An accepted weight row overwrites row 0, resets the counter, and the FSM goes to LOAD. An accepted vector with `act_last` goes to DRAIN.
  - DRAIN: `act_ready=0`, `wt_ready=0`. Return to READY on the cycle `out_last` pulses.
- Weights are stationary. One register per PE holds `W[r][c]`. The set is written only through LOAD and is never modified by activation traffic.
- Dataflow:
  - Activation row `r` is delayed `r` cycles before entering column 0, then passes right one PE per cycle.
  - Bias for column `c` is delayed `c` cycles, then enters row 0 and passes down one PE per cycle.
  - Each PE registers `psum_out = psum_in + a·w` and `a_out = a_in`.
  - Column `c` output is delayed `COLS-1-c` cycles, so all columns emerge together.
- Valid path:
  - A `LAT`-deep shift register of {valid, last} runs in parallel with the data.
  - Bubbles, meaning cycles with no acceptance, produce no `out_valid`.
  - Throughput is one vector per cycle.
- `inflight` counts accepted vectors whose `out_valid` has not yet pulsed. It must never exceed `LAT`.
- Arithmetic:
  - The `DATAWIDTH×DATAWIDTH` signed product is sign-extended to `ACCWIDTH`.
  - Accumulation wraps modulo 2^`ACCWIDTH`, with no saturation.
- `out_data` holds its last value when `out_valid=0`.

## Timing
- Reset: `rst` high asynchronously clears the FSM to IDLE, the row counter, all weights, skew, PE and valid registers, and `inflight`.
  - Output values during reset: `wt_ready=1`, `act_ready=0`, `out_valid=0`, `out_last=0`, `out_data=0`, `wt_loaded=0`.
- Reset mid-tile: in-flight results are discarded. No `out_valid` is produced after release until new weights load and vectors are accepted.
- Latency: a vector accepted on edge k produces `out_valid=1` in the cycle following edge k+`LAT`.
- `act_ready` and `wt_ready` depend only on registered state, plus the `!act_valid` term in READY.
- A vector is accepted on the same edge the last weight row is written? No. `act_ready` is 0 in LOAD, so the first vector can be accepted one cycle after READY entry.
- A back-to-back `act_last` followed by a new tile is legal: DRAIN → READY re-opens `act_ready` the cycle after `out_last`.

## Test plan
- Identity load (ROWS=COLS=4, W=I, bias=0):
  - Stimulus: vector a=(1,-2,3,127) accepted at edge k.
  - Response: `out_data=(1,-2,3,127)` with `out_valid` in the cycle after edge k+8, `out_last` matching `act_last`.
- Streaming:
  - Stimulus: 10 consecutive vectors with all W=1 and bias=(0,10,20,30), a = n·(1,1,1,1) for n=0..9.
  - Response: 10 contiguous `out_valid` pulses, result n = (4n, 4n+10, 4n+20, 4n+30).
- Extremes and wrap:
  - Stimulus: W=-128 everywhere, a=-128, bias=0.
  - Response: every column = 65536.
  - Stimulus: bias=0x7FFFFFFF, a=1, W=1.
  - Response: wraps to 0x80000003.
- Handshake corners:
  - Stimulus: `wt_valid` with gaps during LOAD. Response: only accepted rows count.
  - Stimulus: `wt_valid` and `act_valid` together in READY. Response: the vector is accepted and the weights are not.
  - Stimulus: `act_valid` in DRAIN. Response: ignored until `out_last`.
- Reload:
  - Stimulus: tile 1 with `act_last`, then a new weight set loaded after DRAIN.
  - Response: tile 2 results use only the new weights, with no stale rows.
- Reset mid-stream:
  - Stimulus: assert `rst` 3 cycles after accepting 5 vectors.
  - Response: all outputs take their reset values immediately, with no `out_valid` before a reload and new acceptance.

Source files
------------

// File: rtl/systolic_ws_array_if.sv
// Bus bundle for the weight-stationary systolic array: weight-row load channel,
// activation/bias channel, and the aligned result channel.
interface systolic_ws_array_if #(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 32,
  parameter int ROWS      = 16,
  parameter int COLS      = 16
);
  logic                      wt_valid;
  logic [COLS*DATAWIDTH-1:0] wt_row;
  logic                      wt_ready;

  logic                      act_valid;
  logic [ROWS*DATAWIDTH-1:0] act_in;
  logic [COLS*ACCWIDTH-1:0]  bias_in;
  logic                      act_last;
  logic                      act_ready;

  logic                      out_valid;
  logic [COLS*ACCWIDTH-1:0]  out_data;
  logic                      out_last;
  logic                      wt_loaded;

  // Producer side: drives weights and activations, observes handshakes and results
  modport master (
    output wt_valid, wt_row, act_valid, act_in, bias_in, act_last,
    input  wt_ready, act_ready, out_valid, out_data, out_last, wt_loaded
  );

  // Array side: consumes weights and activations, produces results
  modport slave (
    input  wt_valid, wt_row, act_valid, act_in, bias_in, act_last,
    output wt_ready, act_ready, out_valid, out_data, out_last, wt_loaded
  );
endinterface

// File: rtl/systolic_ws_array.sv
// Weight-stationary ROWS x COLS systolic matrix-multiply engine.
// Each accepted activation vector a[0..ROWS-1] yields one result vector
// out[c] = bias[c] + sum_r a[r]*W[r][c], all columns aligned, LAT cycles later.
// Weights are loaded row by row through a framed load FSM and stay resident.
module systolic_ws_array #(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 32,
  parameter int ROWS      = 16,
  parameter int COLS      = 16
) (
  input logic clk,
  input logic rst,
  systolic_ws_array_if.slave bus
);

  localparam int LAT = ROWS + COLS;
  localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW  = $clog2(LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]               r_state;
  logic [CW-1:0]            r_rowCnt;
  logic [IW-1:0]            r_inflight;
  logic [LAT-1:0]           r_vld;
  logic [LAT-1:0]           r_lst;
  logic                     r_outValid;
  logic                     r_outLast;
  logic [COLS*ACCWIDTH-1:0] r_outData;

  logic                     w_wtReady;
  logic                     w_actReady;
  logic                     w_wtAccept;
  logic                     w_actAccept;
  logic [CW-1:0]            w_wtRowIdx;

  logic signed [DATAWIDTH-1:0] w_aEdge  [ROWS];
  logic signed [ACCWIDTH-1:0]  w_bEdge  [COLS];
  logic signed [DATAWIDTH-1:0] w_aOut   [ROWS][COLS];
  logic signed [ACCWIDTH-1:0]  w_pOut   [ROWS][COLS];
  logic signed [ACCWIDTH-1:0]  w_colOut [COLS];

  // Ready signals come from registered state only, except that a pending
  // activation blocks a weight reload so compute always wins over reload.
  always_comb begin
    w_wtReady  = 1'b0;
    w_actReady = 1'b0;
    case (r_state)
      S_IDLE:  w_wtReady = 1'b1;
      S_LOAD:  w_wtReady = 1'b1;
      S_READY: begin
        w_actReady = 1'b1;
        w_wtReady  = (r_inflight == '0) && !bus.act_valid;
      end
      default: begin
        w_wtReady  = 1'b0;
        w_actReady = 1'b0;
      end
    endcase
  end

  assign w_wtAccept  = bus.wt_valid  && w_wtReady;
  assign w_actAccept = bus.act_valid && w_actReady;

  // The first row of a set always lands in row 0; later rows follow the counter.
  assign w_wtRowIdx = (r_state == S_LOAD) ? r_rowCnt : '0;

  // Load/compute FSM with the implicit weight-row counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rowCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wtAccept) begin
            if (ROWS == 1) begin
              r_state <= S_READY;
            end else begin
              r_state  <= S_LOAD;
              r_rowCnt <= CW'(1);
            end
          end
        end
        S_LOAD: begin
          if (w_wtAccept) begin
            if (r_rowCnt == CW'(ROWS - 1)) begin
              r_state  <= S_READY;
              r_rowCnt <= '0;
            end else begin
              r_rowCnt <= r_rowCnt + CW'(1);
            end
          end
        end
        S_READY: begin
          if (w_actAccept && bus.act_last) begin
            r_state <= S_DRAIN;
          end else if (w_wtAccept) begin
            if (ROWS == 1) begin
              r_state <= S_READY;
            end else begin
              r_state  <= S_LOAD;
              r_rowCnt <= CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_outLast) begin
            r_state <= S_READY;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_rowCnt <= '0;
        end
      endcase
    end
  end

  // Activation skew: row r is delayed r cycles beyond the capture stage
  for (genvar r = 0; r < ROWS; r++) begin : g_aSkew
    logic signed [DATAWIDTH-1:0] r_aSkew [0:r];

    // Capture row r of the incoming vector and shift it down its skew chain
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= r; j++) begin
          r_aSkew[j] <= '0;
        end
      end else begin
        r_aSkew[0] <= bus.act_in[r*DATAWIDTH +: DATAWIDTH];
        for (int j = 1; j <= r; j++) begin
          r_aSkew[j] <= r_aSkew[j-1];
        end
      end
    end

    assign w_aEdge[r] = r_aSkew[r];
  end

  // Bias skew: column c is delayed c cycles so it meets its activations in row 0
  for (genvar c = 0; c < COLS; c++) begin : g_bSkew
    logic signed [ACCWIDTH-1:0] r_bSkew [0:c];

    // Capture the column bias and shift it down its skew chain
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= c; j++) begin
          r_bSkew[j] <= '0;
        end
      end else begin
        r_bSkew[0] <= bus.bias_in[c*ACCWIDTH +: ACCWIDTH];
        for (int j = 1; j <= c; j++) begin
          r_bSkew[j] <= r_bSkew[j-1];
        end
      end
    end

    assign w_bEdge[c] = r_bSkew[c];
  end

  // Processing-element grid: activations flow right, partial sums flow down
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DATAWIDTH-1:0]   r_w;
      logic signed [DATAWIDTH-1:0]   r_a;
      logic signed [ACCWIDTH-1:0]    r_psum;
      logic signed [DATAWIDTH-1:0]   w_aIn;
      logic signed [ACCWIDTH-1:0]    w_pIn;
      logic signed [2*DATAWIDTH-1:0] w_prod;

      if (c == 0) begin : g_aLeft
        assign w_aIn = w_aEdge[r];
      end else begin : g_aInner
        assign w_aIn = w_aOut[r][c-1];
      end

      if (r == 0) begin : g_pTop
        assign w_pIn = w_bEdge[c];
      end else begin : g_pInner
        assign w_pIn = w_pOut[r-1][c];
      end

      assign w_prod = w_aIn * r_w;

      // Stationary weight: written only by a weight row addressed to this row
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_w <= '0;
        end else if (w_wtAccept && (w_wtRowIdx == CW'(r))) begin
          r_w <= bus.wt_row[c*DATAWIDTH +: DATAWIDTH];
        end
      end

      // Multiply-accumulate; the product is sign-extended and the sum wraps
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a    <= '0;
          r_psum <= '0;
        end else begin
          r_a    <= w_aIn;
          r_psum <= w_pIn + ACCWIDTH'(w_prod);
        end
      end

      assign w_aOut[r][c] = r_a;
      assign w_pOut[r][c] = r_psum;
    end
  end

  // Output de-skew: column c waits COLS-1-c cycles so all columns line up
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign w_colOut[c] = w_pOut[ROWS-1][c];
    end else begin : g_delay
      logic signed [ACCWIDTH-1:0] r_dSkew [0:D-1];

      // Shift the bottom-row partial sum through the de-skew chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < D; j++) begin
            r_dSkew[j] <= '0;
          end
        end else begin
          r_dSkew[0] <= w_pOut[ROWS-1][c];
          for (int j = 1; j < D; j++) begin
            r_dSkew[j] <= r_dSkew[j-1];
          end
        end
      end

      assign w_colOut[c] = r_dSkew[D-1];
    end
  end

  // Valid/last tracking runs alongside the datapath; bubbles carry no valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld      <= '0;
      r_lst      <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else begin
      r_vld      <= {r_vld[LAT-2:0], w_actAccept};
      r_lst      <= {r_lst[LAT-2:0], w_actAccept && bus.act_last};
      r_outValid <= r_vld[LAT-1];
      r_outLast  <= r_lst[LAT-1];
    end
  end

  // Result register: updates only with a valid result, otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outData <= '0;
    end else if (r_vld[LAT-1]) begin
      for (int c = 0; c < COLS; c++) begin
        r_outData[c*ACCWIDTH +: ACCWIDTH] <= w_colOut[c];
      end
    end
  end

  // Vectors accepted but not yet emitted; gates weight reload in READY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_actAccept, r_vld[LAT-1]})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.wt_ready  = w_wtReady;
  assign bus.act_ready = w_actReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_last  = r_outLast;
  assign bus.out_data  = r_outData;
  assign bus.wt_loaded = (r_state == S_READY) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_systolic_ws_array.sv
// Self-checking bench for systolic_ws_array (4x4, 8-bit data, 32-bit accumulators).
// Vectors with hand-computed results live in a table; multi-cycle corners
// (load gaps, drain, concurrent handshakes, reset mid-stream) are hand sequences.
module tb_systolic_ws_array;

  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int R   = 4;
  localparam int C   = 4;
  localparam int LAT = R + C;

  typedef struct {
    logic [R*DW-1:0] a;
    logic [C*AW-1:0] bias;
    logic            last;
    logic [C*AW-1:0] expData;
  } vecRec;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  vecRec           tbl [0:18];
  int              accCyc [$];
  logic [C*AW-1:0] resData [$];
  logic            resLast [$];
  int              resCyc [$];

  logic [R*DW-1:0] idRow [4];
  logic [R*DW-1:0] oneRow;
  logic [R*DW-1:0] minRow;

  always #5 clk = ~clk;

  systolic_ws_array_if #(.DATAWIDTH(DW), .ACCWIDTH(AW), .ROWS(R), .COLS(C)) bus ();

  systolic_ws_array #(.DATAWIDTH(DW), .ACCWIDTH(AW), .ROWS(R), .COLS(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Cycle counter used to timestamp acceptances and results
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every result pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      resData.push_back(bus.out_data);
      resLast.push_back(bus.out_last);
      resCyc.push_back(cyc);
    end
  end

  // Hard stop so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [R*DW-1:0] pack8(input int v0, input int v1, input int v2, input int v3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(v0);
    b1 = 8'(v1);
    b2 = 8'(v2);
    b3 = 8'(v3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [C*AW-1:0] pack32(input logic [31:0] v0, input logic [31:0] v1,
                                             input logic [31:0] v2, input logic [31:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  task automatic checkVal(input string nm, input logic [C*AW-1:0] act, input logic [C*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic loadWeights(input logic [R*DW-1:0] w0, input logic [R*DW-1:0] w1,
                             input logic [R*DW-1:0] w2, input logic [R*DW-1:0] w3,
                             input int gap);
    logic [R*DW-1:0] rows [4];
    int n;
    rows[0] = w0;
    rows[1] = w1;
    rows[2] = w2;
    rows[3] = w3;
    for (int i = 0; i < R; i++) begin
      bus.wt_valid = 1'b1;
      bus.wt_row   = rows[i];
      n = 0;
      while (bus.wt_ready !== 1'b1 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) begin
        checks++;
        failures++;
        $display("[TB] FAIL wt_ready_timeout: actual=0 required=1");
      end
      @(posedge clk); #1;
      bus.wt_valid = 1'b0;
      bus.wt_row   = pack8(99, 99, 99, 99);
      if (gap > 0) begin
        if (i < R - 1) begin
          checkVal("load_partial_wt_loaded", bus.wt_loaded, 0);
          checkVal("load_act_ready", bus.act_ready, 0);
        end
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int first, input int count);
    int n;
    accCyc.delete();
    for (int i = first; i < first + count; i++) begin
      bus.act_valid = 1'b1;
      bus.act_in    = tbl[i].a;
      bus.bias_in   = tbl[i].bias;
      bus.act_last  = tbl[i].last;
      n = 0;
      while (bus.act_ready !== 1'b1 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) begin
        checks++;
        failures++;
        $display("[TB] FAIL act_ready_timeout vec%0d: actual=0 required=1", i);
      end
      @(posedge clk); #1;
      accCyc.push_back(cyc);
    end
    bus.act_valid = 1'b0;
    bus.act_last  = 1'b0;
  endtask

  task automatic checkOutput(input int first, input int count);
    logic [C*AW-1:0] d;
    logic            l;
    int              rc;
    int              n;
    for (int i = 0; i < count; i++) begin
      n = 0;
      while (resData.size() == 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (resData.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL vec%0d_timeout: actual=no_result required=result", first + i);
      end else begin
        d  = resData.pop_front();
        l  = resLast.pop_front();
        rc = resCyc.pop_front();
        checkVal($sformatf("vec%0d_data", first + i), d, tbl[first + i].expData);
        checkVal($sformatf("vec%0d_last", first + i), l, tbl[first + i].last);
        checkVal($sformatf("vec%0d_latency", first + i), rc, accCyc[i] + LAT);
      end
    end
  endtask

  initial begin
    int n;
    bus.wt_valid  = 1'b0;
    bus.wt_row    = '0;
    bus.act_valid = 1'b0;
    bus.act_in    = '0;
    bus.bias_in   = '0;
    bus.act_last  = 1'b0;
    rst = 1'b1;

    idRow[0] = pack8(1, 0, 0, 0);
    idRow[1] = pack8(0, 1, 0, 0);
    idRow[2] = pack8(0, 0, 1, 0);
    idRow[3] = pack8(0, 0, 0, 1);
    oneRow   = pack8(1, 1, 1, 1);
    minRow   = pack8(-128, -128, -128, -128);

    tbl[0] = '{a: pack8(1, -2, 3, 127), bias: '0, last: 1'b1,
               expData: pack32(1, 32'hFFFF_FFFE, 3, 127)};
    for (int k = 0; k < 10; k++) begin
      tbl[1 + k] = '{a: pack8(k, k, k, k), bias: pack32(0, 10, 20, 30), last: (k == 9),
                     expData: pack32(4 * k, 4 * k + 10, 4 * k + 20, 4 * k + 30)};
    end
    tbl[11] = '{a: minRow, bias: '0, last: 1'b1,
                expData: pack32(65536, 65536, 65536, 65536)};
    tbl[12] = '{a: pack8(1, 1, 1, 1),
                bias: pack32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
                last: 1'b1,
                expData: pack32(32'h8000_0003, 32'h8000_0003, 32'h8000_0003, 32'h8000_0003)};
    for (int k = 0; k < 5; k++) begin
      tbl[13 + k] = '{a: pack8(k + 1, k + 1, k + 1, k + 1), bias: '0, last: 1'b0, expData: '0};
    end
    tbl[18] = '{a: pack8(5, 6, -7, 8), bias: pack32(100, 0, 0, 32'hFFFF_FFFF), last: 1'b1,
                expData: pack32(105, 6, 32'hFFFF_FFF9, 7)};

    // Reset values
    #1;
    checkVal("rst_wt_ready", bus.wt_ready, 1);
    checkVal("rst_act_ready", bus.act_ready, 0);
    checkVal("rst_out_valid", bus.out_valid, 0);
    checkVal("rst_out_last", bus.out_last, 0);
    checkVal("rst_out_data", bus.out_data, 0);
    checkVal("rst_wt_loaded", bus.wt_loaded, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Identity weights loaded with gaps between rows
    loadWeights(idRow[0], idRow[1], idRow[2], idRow[3], 2);
    checkVal("id_wt_loaded", bus.wt_loaded, 1);
    checkVal("id_act_ready", bus.act_ready, 1);
    applyStimulus(0, 1);

    // Activations offered during DRAIN are ignored until after out_last
    bus.act_valid = 1'b1;
    bus.act_in    = pack8(9, 9, 9, 9);
    bus.bias_in   = '0;
    bus.act_last  = 1'b0;
    checkVal("drain_wt_ready", bus.wt_ready, 0);
    checkVal("drain_wt_loaded", bus.wt_loaded, 1);
    for (int k = 0; k < 5; k++) begin
      checkVal($sformatf("drain_act_ready_%0d", k), bus.act_ready, 0);
      @(posedge clk); #1;
    end
    bus.act_valid = 1'b0;
    n = 0;
    while (bus.out_last !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("drain_out_last_seen", bus.out_last, 1);
    checkVal("drain_act_ready_at_last", bus.act_ready, 0);
    @(posedge clk); #1;
    checkVal("drain_reopen_act_ready", bus.act_ready, 1);
    checkOutput(0, 1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkVal("drain_no_extra_result", resData.size(), 0);

    // Streaming with all-ones weights; a weight row offered alongside must lose
    loadWeights(oneRow, oneRow, oneRow, oneRow, 0);
    bus.wt_valid  = 1'b1;
    bus.wt_row    = pack8(5, 5, 5, 5);
    bus.act_valid = 1'b1;
    bus.act_in    = tbl[1].a;
    bus.bias_in   = tbl[1].bias;
    bus.act_last  = tbl[1].last;
    #1;
    checkVal("concurrent_wt_ready", bus.wt_ready, 0);
    checkVal("concurrent_act_ready", bus.act_ready, 1);
    applyStimulus(1, 10);
    bus.wt_valid = 1'b0;
    checkVal("stream_contiguous_accept", accCyc[9] - accCyc[0], 9);
    checkOutput(1, 10);

    // Extreme operands: (-128)*(-128) summed over four rows
    loadWeights(minRow, minRow, minRow, minRow, 0);
    applyStimulus(11, 1);
    checkOutput(11, 1);

    // Reload with ones and wrap the accumulator past the positive limit
    loadWeights(oneRow, oneRow, oneRow, oneRow, 0);
    applyStimulus(12, 1);
    checkOutput(12, 1);

    // Reset in the middle of a stream discards everything in flight
    applyStimulus(13, 5);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checkVal("midrst_out_valid", bus.out_valid, 0);
    checkVal("midrst_out_last", bus.out_last, 0);
    checkVal("midrst_out_data", bus.out_data, 0);
    checkVal("midrst_wt_loaded", bus.wt_loaded, 0);
    checkVal("midrst_act_ready", bus.act_ready, 0);
    checkVal("midrst_wt_ready", bus.wt_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    checkVal("postrst_no_result", resData.size(), 0);
    checkVal("postrst_wt_loaded", bus.wt_loaded, 0);
    checkVal("postrst_act_ready", bus.act_ready, 0);

    // Fresh identity load after reset
    loadWeights(idRow[0], idRow[1], idRow[2], idRow[3], 0);
    applyStimulus(18, 1);
    checkOutput(18, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
